// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment scan controller. Holds a shadow bank of per-digit hex values
// that hosts write into, and a display bank that is refreshed from the shadow
// bank once per frame. The controller drives one digit at a time on shared,
// active-low segment lines, with a dark guard interval before each digit to
// avoid ghosting.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          blank_en,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  output logic                          wr_ready,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic                          frame_done
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

  // A slot opens with a guard unless the guard length is zero.
  localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? GUARD : SHOW;

  state_t          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [6:0]      seg_reg, seg_next;
  logic [NUM_DIGITS-1:0] dig_sel_reg, dig_sel_next;
  logic            frame_done_reg, frame_done_next;
  logic            wr_ready_reg, wr_ready_next;

  logic [3:0]      shadow_reg  [NUM_DIGITS];
  logic [3:0]      display_reg [NUM_DIGITS];
  logic [3:0]      display_next[NUM_DIGITS];

  logic                  slot_end;
  logic                  commit;
  logic                  entering_show;
  logic [NUM_DIGITS-1:0] wr_hit;
  logic [NUM_DIGITS:0]   zero_from;
  logic [NUM_DIGITS-1:0] blank_mask;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Per-digit write decode: an address with no matching digit writes nothing.
  // Leading-zero chain: zero_from[k] is set when every digit from k upward is 0.
  assign zero_from[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign wr_hit[gi]    = wr_en & wr_ready_reg & (wr_addr == AW'(gi));
      assign zero_from[gi] = (display_next[gi] == 4'h0) & zero_from[gi+1];
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = blank_en & zero_from[gi];
      end
    end
  endgenerate

  assign slot_end = (state_reg == SHOW) && (cnt_reg == CNT_LAST);

  // Next-state, slot counter and digit index sequencing.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = SLOT_START;
          idx_next   = '0;
          cnt_next   = '0;
        end
        GUARD: begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == GUARD_LAST) state_next = SHOW;
        end
        SHOW: begin
          if (slot_end) begin
            cnt_next   = '0;
            state_next = SLOT_START;
            if (idx_reg == IDX_LAST) begin
              idx_next = '0;
              commit   = 1'b1;
            end else begin
              idx_next = idx_reg + AW'(1);
            end
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Display bank as it will be after this edge, so a slot entered on the
  // commit edge already shows the new frame's values.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      display_next[i] = commit ? shadow_reg[i] : display_reg[i];
    end
  end

  // Registered outputs track the state being entered; segments latch only on
  // SHOW entry so blank_en changes never alter a digit mid-slot.
  always_comb begin
    entering_show   = (state_next == SHOW) && !((state_reg == SHOW) && !slot_end);
    seg_next        = 7'h7F;
    dig_sel_next    = '1;
    frame_done_next = commit;
    wr_ready_next   = !((state_next == SHOW) && (idx_next == IDX_LAST) && (cnt_next == CNT_LAST));
    if (state_next == SHOW) begin
      dig_sel_next = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_next);
      if (entering_show) begin
        seg_next = blank_mask[idx_next] ? 7'h7F : hex_to_seg(display_next[idx_next]);
      end else begin
        seg_next = seg_reg;
      end
    end
  end

  // FSM state, counters and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      seg_reg        <= 7'h7F;
      dig_sel_reg    <= '1;
      frame_done_reg <= 1'b0;
      wr_ready_reg   <= 1'b1;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      seg_reg        <= seg_next;
      dig_sel_reg    <= dig_sel_next;
      frame_done_reg <= frame_done_next;
      wr_ready_reg   <= wr_ready_next;
    end
  end

  // Shadow bank takes host writes; display bank copies it whole at commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_reg[i]  <= '0;
        display_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr_hit[i]) shadow_reg[i] <= wr_data;
        if (commit) display_reg[i] <= shadow_reg[i];
      end
    end
  end

  assign seg        = seg_reg;
  assign dig_sel    = dig_sel_reg;
  assign frame_done = frame_done_reg;
  assign wr_ready   = wr_ready_reg;

endmodule
